// File: rtl/sample_capture_pkg.sv
// Shared types and constants for the sample capture block.
package sample_capture_pkg;

    typedef enum logic {
        BASELINE = 1'b0,
        RUN      = 1'b1
    } state_t;

    localparam int DW_DEF    = 16;
    localparam int DEPTH_DEF = 4;
    localparam int SUM_W     = 32;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/sample_capture_fifo.sv
// Small FIFO for captured samples; the head entry is visible combinationally
// so a push shows up on the output right after the writing edge.
module sample_capture_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic          push_ok,
    output logic          pop_ok
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   occ_reg;

    assign empty   = (occ_reg == '0);
    assign full    = (occ_reg == FULL_OCC);
    assign pop_ok  = pop && !empty && !clr;
    // A full FIFO still takes a new entry when the head leaves on the same edge.
    assign push_ok = push && !clr && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Captures each change of a strobe-less result bus into a FIFO and keeps
// saturating statistics of the accepted samples.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_data,
    input  logic             clr,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    state_t           state_reg;
    logic [DW-1:0]    prev_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;

    logic             change;
    logic             push_req;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push_ok;
    logic             pop_ok;
    logic [SUM_W:0]   sum_ext;
    logic [CNT_W:0]   count_ext;

    assign change   = (state_reg == RUN) && (in_data != prev_reg);
    assign push_req = change && !clr;

    sample_capture_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (push_req),
        .pop     (out_ready),
        .wr_data (in_data),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .push_ok (push_ok),
        .pop_ok  (pop_ok)
    );

    assign out_valid = !fifo_empty;

    // The carry bit of the extended add marks saturation.
    always_comb begin
        sum_ext    = {1'b0, sum_reg} + (SUM_W+1)'(in_data);
        count_ext  = {1'b0, count_reg} + 1'b1;
        sum_next   = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        count_next = count_ext[CNT_W] ? {CNT_W{1'b1}} : count_ext[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= BASELINE;
            prev_reg     <= '0;
            sum_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                BASELINE: begin
                    prev_reg  <= in_data;
                    state_reg <= RUN;
                end
                RUN: begin
                    if (change) begin
                        prev_reg <= in_data;
                    end
                end
                default: state_reg <= BASELINE;
            endcase

            if (clr) begin
                sum_reg      <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push_ok) begin
                    sum_reg   <= sum_next;
                    count_reg <= count_next;
                end
                if (change && fifo_full && !pop_ok) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    assign sum      = sum_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter DW, default 16, data width; matches the 16-bit `out` bus of the upstream stage.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  DW  upstream result bus; has no strobe, so a new value is inferred from a change.
REQ-006 clr  input  1  synchronous clear of FIFO, statistics and overflow flag.
REQ-007 out_data  output  DW  head-of-FIFO value, valid only while out_valid=1.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts the head entry when out_valid&&out_ready at a rising edge.
REQ-010 sum  output  32  saturating sum of accepted samples (zero-extended).
REQ-011 count  output  16  saturating count of accepted samples.
REQ-012 overflow  output  1  sticky; a change was dropped because the FIFO was full.

Function
REQ-013 Capture FSM SHALL have states BASELINE and RUN; reset enters BASELINE.
REQ-014 In BASELINE, the first edge after reset release SHALL load prev<=in_data, push nothing, and go to RUN.
REQ-015 In RUN, each edge SHALL compare in_data with prev; if different, raise a push request and set prev<=in_data; if equal, do nothing.
REQ-016 A pushed entry SHALL be visible on out_data/out_valid immediately after the capturing edge; latency is 1 edge from in_data change to out_valid.
REQ-017 Pop occurs on an edge with out_valid&&out_ready; the next entry, or out_valid=0, appears after that edge.
REQ-018 FIFO full with push and no pop: drop the sample, set overflow=1, leave sum/count unchanged; prev still updates.
REQ-019 FIFO full with push and pop on the same edge: accept both; occupancy stays DEPTH; no overflow.
REQ-020 FIFO empty with push: out_valid=0 during that cycle; no bypass, so the pop cannot occur on the same edge.
REQ-021 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be held in a log2(DEPTH)+1-bit counter.
REQ-022 Each accepted push: sum<=min(sum+in_data, 32'hFFFFFFFF) and count<=min(count+1, 16'hFFFF).
REQ-023 clr=1 SHALL empty the FIFO and zero sum, count and overflow; FSM state and prev are kept; a push on the same edge is discarded.
REQ-024 out_ready with out_valid=0 has no effect.

Reset
REQ-025 rst=0 SHALL immediately force: state=BASELINE, prev=0, FIFO empty, out_valid=0, out_data=0, sum=0, count=0, overflow=0.
REQ-026 Reset asserted mid-transfer SHALL discard all FIFO contents; after release, the BASELINE rule of REQ-014 applies again.

Structure
REQ-027 Package sample_capture_pkg SHALL hold the FSM state encoding (BASELINE=0, RUN=1), the defaults DW=16 and DEPTH=4, and the SUM_W=32 and CNT_W=16 constants.
REQ-028 The storage SHALL be one sub-module, sample_capture_fifo: push/pop, full/empty and occupancy logic, with the same clk/rst.
REQ-029 The top level SHALL hold the FSM, the change detector and the statistics.

Verification
REQ-030 Reset release, in_data held at 10 for 5 cycles -> no push; out_valid=0; count=0.
REQ-031 in_data sequence 10, 20, 20, 30 with out_ready=1 -> outputs 20 then 30, each valid 1 cycle after its change; sum=50; count=2.
REQ-032 out_ready=0, in_data changes 6 times (1..6) with DEPTH=4 -> FIFO holds 1,2,3,4; overflow=1; count=4; draining yields 1,2,3,4 in order.
REQ-033 FIFO full, out_ready=1 and a change to 99 on the same edge -> occupancy stays 4; 99 appears last; overflow stays 0.
REQ-034 sum preloaded near 32'hFFFFFFF0, then push 0xFFFF -> sum=32'hFFFFFFFF; a further push keeps sum saturated.
REQ-035 rst pulsed low with 3 entries queued -> out_valid=0 at once; after release, first edge is BASELINE (no push); clr mid-run -> sum=0, count=0, overflow=0.
